// File: rtl/falafel_pkg.sv
// Shared falafel types: LSU request/response structs and LSU arbiter definitions.
package falafel_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        STORE  = 2'd1,
        LOCK   = 2'd2,
        UNLOCK = 2'd3
    } req_lsu_op_e;

    localparam int unsigned HEADER_DATA_W = 32;
    typedef logic [HEADER_DATA_W-1:0] header_data_t;

    typedef struct packed {
        logic         val;
        req_lsu_op_e  lsu_op;
        header_data_t header_data;
    } header_data_req_t;

    typedef struct packed {
        logic         val;
        header_data_t header_data;
    } header_data_rsp_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OWNED    = 2'd1,
        WAIT_RSP = 2'd2
    } arb_state_e;

    localparam int unsigned ARB_TIMEOUT_DEFAULT = 1024;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/falafel_rr_picker.sv
// Round-robin picker: first valid master at or after rr_ptr, wrapping modulo NUM_REQ.
module falafel_rr_picker
    import falafel_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    localparam int unsigned IW = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IW-1:0]      rr_ptr_i,
    output logic [IW-1:0]      grant_o,
    output logic               any_valid_o
);

    int unsigned idx;
    logic [IW-1:0] cand;

    always_comb begin
        grant_o     = '0;
        any_valid_o = 1'b0;
        idx         = 0;
        cand        = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx  = (int'(rr_ptr_i) + i) % NUM_REQ;
            cand = IW'(idx);
            if (!any_valid_o && valid_i[cand]) begin
                grant_o     = cand;
                any_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/falafel_lsu_arbiter.sv
// Round-robin arbiter sharing the header LSU port, with exclusive lock sessions.
// Optional watchdog enabled by defining FALAFEL_ARB_TIMEOUT_EN.
module falafel_lsu_arbiter
    import falafel_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  header_data_req_t [NUM_REQ-1:0]       req_i,
    output logic             [NUM_REQ-1:0]       ready_o,
    output header_data_rsp_t [NUM_REQ-1:0]       rsp_o,
    output header_data_req_t                     req_o,
    input  logic                                 lsu_ready_i,
    input  header_data_rsp_t                     rsp_i,
    output logic                                 err_timeout_o
);

    localparam int unsigned IW = idx_w(NUM_REQ);

    arb_state_e    state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] owner;
    logic          locked;
    req_lsu_op_e   op_q;

    logic [NUM_REQ-1:0] valid_vec;
    logic [IW-1:0]      grant;
    logic               any_valid;
    logic               accept;
    logic               routed;
    logic [IW-1:0]      next_ptr;

    always_comb begin
        valid_vec = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            valid_vec[i] = req_i[i].val;
        end
    end

    falafel_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .valid_i     (valid_vec),
        .rr_ptr_i    (rr_ptr),
        .grant_o     (grant),
        .any_valid_o (any_valid)
    );

    // Outputs are gated by rst_ni so a reset takes the LSU request down immediately.
    always_comb begin
        req_o   = '0;
        ready_o = '0;
        rsp_o   = '0;
        if (rst_ni) begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        req_o          = req_i[grant];
                        ready_o[grant] = lsu_ready_i;
                    end
                end
                OWNED: begin
                    req_o          = req_i[owner];
                    ready_o[owner] = lsu_ready_i;
                end
                WAIT_RSP: begin
                    if (rsp_i.val) begin
                        rsp_o[owner] = rsp_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign accept   = req_o.val && lsu_ready_i;
    assign routed   = (state == WAIT_RSP) && rsp_i.val;
    assign next_ptr = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
            locked <= 1'b0;
            op_q   <= UNLOCK;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner  <= grant;
                        op_q   <= req_o.lsu_op;
                        locked <= (req_o.lsu_op == LOCK);
                        state  <= WAIT_RSP;
                    end
                end
                OWNED: begin
                    if (accept) begin
                        op_q  <= req_o.lsu_op;
                        state <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (rsp_i.val) begin
                        if (!locked || op_q == UNLOCK) begin
                            locked <= 1'b0;
                            rr_ptr <= next_ptr;
                            state  <= IDLE;
                        end else begin
                            state <= OWNED;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FALAFEL_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] to_cnt;
    logic [CW-1:0] to_cnt_nxt;
    logic          err_q;

    always_comb begin
        to_cnt_nxt = to_cnt;
        if (accept || routed || state == IDLE) begin
            to_cnt_nxt = '0;
        end else if (to_cnt != TO_LIMIT) begin
            to_cnt_nxt = to_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            to_cnt <= to_cnt_nxt;
            if (to_cnt_nxt == TO_LIMIT) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_timeout_o = err_q;
`else
    assign err_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_falafel_lsu_arbiter.sv
// Bench for falafel_lsu_arbiter: transaction-level model checked every cycle plus directed literals.
module tb_falafel_lsu_arbiter;
    import falafel_pkg::*;

    localparam int unsigned N  = 2;
    localparam int          TO = 16;
`ifdef FALAFEL_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    header_data_req_t [N-1:0] req_i;
    logic             [N-1:0] ready_o;
    header_data_rsp_t [N-1:0] rsp_o;
    header_data_req_t         req_o;
    logic                     lsu_ready;
    header_data_rsp_t         rsp_i;
    logic                     err;

    falafel_lsu_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_i         (req_i),
        .ready_o       (ready_o),
        .rsp_o         (rsp_o),
        .req_o         (req_o),
        .lsu_ready_i   (lsu_ready),
        .rsp_i         (rsp_i),
        .err_timeout_o (err)
    );

    int asserts = 0;
    int fails   = 0;
    int cyc     = 0;

    header_data_req_t mq[N][$];
    bit               popped[N];
    bit               acc_seen;
    header_data_t     acc_data;
    bit               stray_rsp;

    // Model: which master has a transaction in flight, who holds the lock, whose turn is next.
    int          inflight    = -1;
    req_lsu_op_e inflight_op = UNLOCK;
    int          holder      = -1;
    int          next_pri    = 0;
    int          to_cnt_m    = 0;
    bit          err_m       = 1'b0;

    int           log_m[$];
    req_lsu_op_e  log_op[$];
    header_data_t log_data[$];
    int           log_cyc[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic header_data_req_t mk(input req_lsu_op_e op, input header_data_t d);
        header_data_req_t r;
        r.val         = 1'b1;
        r.lsu_op      = op;
        r.header_data = d;
        return r;
    endfunction

    always @(negedge clk) begin : cmp
        header_data_req_t         e_req;
        logic             [N-1:0] e_ready;
        header_data_rsp_t [N-1:0] e_rsp;
        bit acc, routed, idle_before;
        int w;
        e_req   = '0;
        e_ready = '0;
        e_rsp   = '0;
        acc     = 1'b0;
        routed  = 1'b0;
        w       = -1;
        if (!rst_n) begin
            inflight = -1;
            holder   = -1;
            next_pri = 0;
            to_cnt_m = 0;
            err_m    = 1'b0;
            acc_seen = 1'b0;
            for (int m = 0; m < N; m++) popped[m] = 1'b0;
            check("rst_req", req_o, e_req);
            check("rst_ready", ready_o, e_ready);
            check("rst_rsp", rsp_o, e_rsp);
            check("rst_err", err, 1'b0);
        end else begin
            idle_before = (inflight < 0) && (holder < 0);
            if (inflight >= 0) begin
                if (rsp_i.val) begin
                    e_rsp[inflight] = rsp_i;
                    routed = 1'b1;
                end
            end else begin
                if (holder >= 0) begin
                    w = holder;
                end else begin
                    for (int k = 0; k < N; k++) begin
                        if (w < 0 && req_i[(next_pri + k) % N].val) w = (next_pri + k) % N;
                    end
                end
                if (w >= 0) begin
                    e_req      = req_i[w];
                    e_ready[w] = lsu_ready;
                    acc        = req_i[w].val && lsu_ready;
                end
            end
            check("req_o", req_o, e_req);
            check("ready_o", ready_o, e_ready);
            check("rsp_o", rsp_o, e_rsp);
            check("err_timeout_o", err, err_m);

            for (int m = 0; m < N; m++) begin
                if (req_i[m].val && ready_o[m]) popped[m] = 1'b1;
            end
            if (req_o.val && lsu_ready) begin
                acc_seen = 1'b1;
                acc_data = req_o.header_data;
            end

            if (acc) begin
                inflight    = w;
                inflight_op = req_i[w].lsu_op;
                if (req_i[w].lsu_op == LOCK) holder = w;
                log_m.push_back(w);
                log_op.push_back(req_i[w].lsu_op);
                log_data.push_back(req_i[w].header_data);
                log_cyc.push_back(cyc);
            end
            if (routed) begin
                if (holder < 0 || inflight_op == UNLOCK) begin
                    holder   = -1;
                    next_pri = (inflight + 1) % N;
                end
                inflight = -1;
            end
            if (acc || routed || idle_before) to_cnt_m = 0;
            else if (to_cnt_m < TO) to_cnt_m++;
            if (TO_EN && to_cnt_m == TO) err_m = 1'b1;
        end
    end

    // Advance one cycle: masters present queue heads, the LSU answers one cycle after accept.
    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        for (int m = 0; m < N; m++) begin
            if (popped[m]) begin
                if (mq[m].size() > 0) void'(mq[m].pop_front());
                popped[m] = 1'b0;
            end
            req_i[m] = (mq[m].size() > 0) ? mq[m][0] : '0;
        end
        if (acc_seen) begin
            rsp_i.val         = 1'b1;
            rsp_i.header_data = acc_data ^ 32'h5A5A_0000;
        end else if (stray_rsp) begin
            rsp_i.val         = 1'b1;
            rsp_i.header_data = 32'hDEAD_BEEF;
        end else begin
            rsp_i = '0;
        end
        acc_seen = 1'b0;
    endtask

    task automatic drain(input string name, input int max_cyc);
        int n = 0;
        while ((mq[0].size() > 0 || mq[1].size() > 0 || inflight >= 0 || acc_seen) && n < max_cyc) begin
            cycle();
            n++;
        end
        if (n >= max_cyc) begin
            asserts++;
            fails++;
            $display("FAIL %s: drain timeout after %0d cycles, required completion", name, n);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int m = 0; m < N; m++) mq[m].delete();
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "bench timeout");
    end

    initial begin
        int base;
        int c_set;
        rst_n     = 1'b0;
        req_i     = '0;
        rsp_i     = '0;
        lsu_ready = 1'b1;
        stray_rsp = 1'b0;
        acc_seen  = 1'b0;
        for (int m = 0; m < N; m++) popped[m] = 1'b0;
        do_reset();

        // 1: master 0 lock session, then round-robin pointer must favour master 1
        mq[0].push_back(mk(LOCK, 32'h1));
        mq[0].push_back(mk(LOAD, 32'h10));
        mq[0].push_back(mk(UNLOCK, 32'h2));
        drain("t1", 100);
        check("t1_count", log_m.size(), 3);
        check("t1_m0", log_m[0], 0);
        check("t1_m2", log_m[2], 0);
        check("t1_op1", log_op[1], LOAD);
        check("t1_addr", log_data[1], 32'h10);
        check("t1_gap", log_cyc[1] - log_cyc[0], 2);
        base = log_m.size();
        mq[0].push_back(mk(LOAD, 32'h20));
        mq[1].push_back(mk(LOAD, 32'h21));
        drain("t1_rr", 100);
        check("t1_rr_first", log_m[base], 1);
        check("t1_rr_second", log_m[base + 1], 0);

        // 2: simultaneous LOCKs, master 0 keeps exclusivity until its UNLOCK response
        do_reset();
        log_m.delete(); log_op.delete(); log_data.delete(); log_cyc.delete();
        mq[0].push_back(mk(LOCK, 32'hA0));
        mq[0].push_back(mk(LOAD, 32'hA1));
        mq[0].push_back(mk(UNLOCK, 32'hA2));
        mq[1].push_back(mk(LOCK, 32'hB0));
        mq[1].push_back(mk(LOAD, 32'hB1));
        mq[1].push_back(mk(UNLOCK, 32'hB2));
        drain("t2", 200);
        check("t2_count", log_m.size(), 6);
        for (int i = 0; i < 6; i++) check("t2_order", log_m[i], (i < 3) ? 0 : 1);
        check("t2_m1_lock", log_op[3], LOCK);
        check("t2_handover", log_cyc[3] - log_cyc[2], 2);

        // 3: continuous LOADs from both masters alternate
        base = log_m.size();
        for (int i = 0; i < 4; i++) begin
            mq[0].push_back(mk(LOAD, 32'h100 + i));
            mq[1].push_back(mk(LOAD, 32'h200 + i));
        end
        drain("t3", 200);
        for (int i = 0; i < 8; i++) check("t3_alt", log_m[base + i], i % 2);

        // 4: stray response ignored; LSU back-pressure holds master 1's request
        stray_rsp = 1'b1;
        cycle();
        stray_rsp = 1'b0;
        cycle();
        lsu_ready = 1'b0;
        mq[1].push_back(mk(LOAD, 32'h44));
        cycle();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("t4_val", req_o.val, 1'b1);
            check("t4_data", req_o.header_data, 32'h44);
            check("t4_ready", ready_o, 2'b00);
            cycle();
        end
        lsu_ready = 1'b1;
        c_set = cyc;
        base  = log_m.size();
        drain("t4", 50);
        check("t4_master", log_m[base], 1);
        check("t4_acc_cycle", log_cyc[base], c_set);

        // 5: reset while master 0 owns the port
        mq[0].push_back(mk(LOCK, 32'h50));
        drain("t5_lock", 50);
        lsu_ready = 1'b0;
        mq[0].push_back(mk(LOAD, 32'h51));
        mq[1].push_back(mk(LOCK, 32'h61));
        cycle();
        @(negedge clk);
        #1;
        check("t5_owner_fwd", req_o.header_data, 32'h51);
        check("t5_blocked", ready_o, 2'b00);
        cycle();
        rst_n = 1'b0;
        #1;
        check("t5_rst_val", req_o.val, 1'b0);
        mq[0].delete();
        cycle();
        cycle();
        rst_n     = 1'b1;
        lsu_ready = 1'b1;
        base      = log_m.size();
        mq[1].push_back(mk(UNLOCK, 32'h62));
        drain("t5", 50);
        check("t5_m1", log_m[base], 1);
        check("t5_op", log_op[base], LOCK);
        check("t5_unlock", log_op[base + 1], UNLOCK);

        // 6: silent lock holder trips the watchdog exactly TO cycles after entering OWNED
        mq[0].push_back(mk(LOCK, 32'h70));
        drain("t6_lock", 50);
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            #1;
            check("t6_err", err, TO_EN && (j >= 16));
            cycle();
        end
        mq[0].push_back(mk(UNLOCK, 32'h71));
        drain("t6", 50);
        cycle();
        check("t6_sticky", err, TO_EN);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
